// File: rtl/proc_ctrl_pkg.sv
// proc_ctrl_pkg: shared types for the processor run controller.
// Holds the FSM state encoding (fixed so the debug display can decode it)
// and the Mode input constants.
package proc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SINGLE = 3'd1,
    S_BURST  = 3'd2,
    S_RUN    = 3'd3,
    S_SETTLE = 3'd4,
    S_BREAK  = 3'd5
  } run_state_t;

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_BURST  = 2'b01;
  localparam logic [1:0] MODE_BREAK  = 2'b10;
  localparam logic [1:0] MODE_FREE   = 2'b11;

endpackage

// File: rtl/rate_divider.sv
// rate_divider: paces run/burst stepping. Counts 0..RUN_DIV-1 while
// enabled and pulses Tick on the cycle the count sits at RUN_DIV-1.
// The count is forced back to 0 whenever it is disabled or cleared.
module rate_divider #(
  parameter int RUN_DIV = 25_000_000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Clear,
  input  logic Enable,
  output logic Tick
);

  localparam int CW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(RUN_DIV - 1);

  logic [CW-1:0] count;

  // Free-running modulo counter, held at zero while idle or cleared
  always_ff @(posedge Clk) begin
    if (Reset || Clear || !Enable) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign Tick = Enable && (count == LAST);

endmodule

// File: rtl/run_controller.sv
// run_controller: turns key strobes into single-cycle processor step
// enables in single, burst, free-run and run-to-breakpoint modes.
// Optional feature macro: BREAKPOINT_EN enables the run-to-breakpoint
// mode; without it Mode 10 behaves as free-run and BreakHit stays 0.
module run_controller
  import proc_ctrl_pkg::*;
#(
  parameter int PC_W    = 7,
  parameter int CNT_W   = 16,
  parameter int RUN_DIV = 25_000_000,
  parameter int BURST_N = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Strobe,
  input  logic [1:0]       Mode,
  input  logic [PC_W-1:0]  BreakPC,
  input  logic [PC_W-1:0]  PC_In,
  output logic             Step,
  output logic             Running,
  output logic             BreakHit,
  output logic [2:0]       State,
  output logic [CNT_W-1:0] StepCount
);

  localparam int BL_W = $clog2(BURST_N + 1);

  run_state_t      state_q;
  logic [1:0]      mode_q;
  logic [BL_W-1:0] burst_left;
  logic            break_hit_q;
  logic            tick;
  logic            div_enable;
  logic            div_clear;
  logic            bp_mode;
  logic            pc_match;

  assign div_enable = (state_q == S_BURST) || (state_q == S_RUN) ||
                      (state_q == S_SETTLE);
  assign div_clear  = (state_q == S_IDLE) && Strobe;

  rate_divider #(
    .RUN_DIV (RUN_DIV)
  ) u_divider (
    .Clk    (Clk),
    .Reset  (Reset),
    .Clear  (div_clear),
    .Enable (div_enable),
    .Tick   (tick)
  );

`ifdef BREAKPOINT_EN
  assign bp_mode  = (mode_q == MODE_BREAK);
  assign pc_match = (PC_In == BreakPC);
  assign BreakHit = break_hit_q;
`else
  logic unused_bp;
  assign bp_mode   = 1'b0;
  assign pc_match  = 1'b0;
  assign BreakHit  = 1'b0;
  assign unused_bp = ^{BreakPC, PC_In, mode_q, break_hit_q};
`endif

  // Step fires on the tick cycle itself; a coincident Strobe cancels it
  // so a stop request never lets one more instruction slip through.
  always_comb begin
    Step = 1'b0;
    if (!Reset) begin
      case (state_q)
        S_SINGLE:     Step = 1'b1;
        S_BURST,
        S_RUN:        Step = tick && !Strobe;
        default:      Step = 1'b0;
      endcase
    end
  end

  // Sequencing FSM; Running and BreakHit are registered with the state
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      mode_q      <= MODE_SINGLE;
      burst_left  <= '0;
      Running     <= 1'b0;
      break_hit_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Strobe) begin
            mode_q <= Mode;
            case (Mode)
              MODE_SINGLE: begin
                state_q <= S_SINGLE;
                Running <= 1'b0;
              end
              MODE_BURST: begin
                state_q    <= S_BURST;
                Running    <= 1'b1;
                burst_left <= BL_W'(BURST_N);
              end
              default: begin
                state_q <= S_RUN;
                Running <= 1'b1;
              end
            endcase
          end
        end
        S_SINGLE: begin
          state_q <= S_IDLE;
          Running <= 1'b0;
        end
        S_BURST: begin
          if (Strobe) begin
            state_q <= S_IDLE;
            Running <= 1'b0;
          end else if (tick) begin
            burst_left <= burst_left - BL_W'(1);
            if (burst_left == BL_W'(1)) begin
              state_q <= S_IDLE;
              Running <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (Strobe) begin
            state_q <= S_IDLE;
            Running <= 1'b0;
          end else if (tick && bp_mode) begin
            state_q <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (Strobe) begin
            state_q <= S_IDLE;
            Running <= 1'b0;
          end else if (pc_match) begin
            state_q     <= S_BREAK;
            Running     <= 1'b0;
            break_hit_q <= 1'b1;
          end else begin
            state_q <= S_RUN;
          end
        end
        S_BREAK: begin
          if (Strobe) begin
            state_q     <= S_IDLE;
            break_hit_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          Running     <= 1'b0;
          break_hit_q <= 1'b0;
        end
      endcase
    end
  end

  // Total step pulses since reset, wrapping at the counter width
  always_ff @(posedge Clk) begin
    if (Reset) begin
      StepCount <= '0;
    end else if (Step) begin
      StepCount <= StepCount + CNT_W'(1);
    end
  end

  assign State = state_q;

endmodule

// File: tb/tb_run_controller.sv
// tb_run_controller: directed bench for run_controller with a short
// divider (4), short burst (3) and a 4-bit step counter so wrap-around
// is reachable. A small PC model advances on every Step.
`timescale 1ns/1ps
module tb_run_controller;
  import proc_ctrl_pkg::*;

  localparam int PC_W    = 7;
  localparam int CNT_W   = 4;
  localparam int RUN_DIV = 4;
  localparam int BURST_N = 3;

  logic             Clk;
  logic             Reset;
  logic             Strobe;
  logic [1:0]       Mode;
  logic [PC_W-1:0]  BreakPC;
  logic [PC_W-1:0]  PC_In;
  logic             Step;
  logic             Running;
  logic             BreakHit;
  logic [2:0]       State;
  logic [CNT_W-1:0] StepCount;

  int vectorCount = 0;
  int missCount   = 0;

  logic [PC_W-1:0] pc;
  logic            pcLoad;
  logic [PC_W-1:0] pcLoadVal;
  logic            prevStep   = 1'b0;
  int              backToBack = 0;

  run_controller #(
    .PC_W    (PC_W),
    .CNT_W   (CNT_W),
    .RUN_DIV (RUN_DIV),
    .BURST_N (BURST_N)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Strobe    (Strobe),
    .Mode      (Mode),
    .BreakPC   (BreakPC),
    .PC_In     (PC_In),
    .Step      (Step),
    .Running   (Running),
    .BreakHit  (BreakHit),
    .State     (State),
    .StepCount (StepCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  assign PC_In = pc;

  // Processor PC model: advances once per Step pulse
  always @(negedge Clk) begin
    if (pcLoad) pc <= pcLoadVal;
    else if (Step) pc <= pc + 1'b1;
  end

  // Watch for Step high on two consecutive cycles
  always @(negedge Clk) begin
    if (Step && prevStep) backToBack++;
    prevStep = Step;
  end

  // Compare one observed value with its expected value
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Run n cycles from just after a rising edge; Strobe is raised in the
  // cycles flagged in strobeMask and Step is recorded per cycle
  task automatic applyStimulus(input int n, input logic [63:0] strobeMask,
                               output logic [63:0] stepMask);
    stepMask = '0;
    for (int i = 0; i < n; i++) begin
      Strobe = strobeMask[i];
      @(negedge Clk);
      stepMask[i] = Step;
      @(posedge Clk);
      #1;
      Strobe = 1'b0;
    end
  endtask

  initial begin
    logic [63:0] m;
    int          nSteps;
    logic        hit;

    Reset     = 1'b1;
    Strobe    = 1'b0;
    Mode      = MODE_SINGLE;
    BreakPC   = '0;
    pcLoad    = 1'b1;
    pcLoadVal = '0;
    repeat (3) @(posedge Clk);
    #1;
    Reset  = 1'b0;
    pcLoad = 1'b0;
    $display("[TB] reset released");

    checkOutput("rst_state", State, S_IDLE);
    checkOutput("rst_step", Step, 0);
    checkOutput("rst_running", Running, 0);
    checkOutput("rst_breakhit", BreakHit, 0);
    checkOutput("rst_count", StepCount, 0);

    // Single step: strobes at 0,3,6 -> steps at 1,4,7
    applyStimulus(9, 64'h49, m);
    checkOutput("single_steps", m, 64'h92);
    checkOutput("single_count", StepCount, 3);
    checkOutput("single_state", State, S_IDLE);

    // Burst of 3: steps at 4,8,12 then idle
    Mode = MODE_BURST;
    applyStimulus(6, 64'h1, m);
    checkOutput("burst_first", m, 64'h10);
    checkOutput("burst_state", State, S_BURST);
    checkOutput("burst_running", Running, 1);
    applyStimulus(8, 64'h0, m);
    checkOutput("burst_rest", m, 64'h44);
    checkOutput("burst_done_state", State, S_IDLE);
    checkOutput("burst_done_running", Running, 0);
    checkOutput("burst_count", StepCount, 6);

    // Burst aborted by a strobe at cycle 6: only the step at 4
    applyStimulus(12, 64'h41, m);
    checkOutput("abort_steps", m, 64'h10);
    checkOutput("abort_state", State, S_IDLE);
    checkOutput("abort_count", StepCount, 7);

`ifdef BREAKPOINT_EN
    // Run to breakpoint 5 from PC 0: steps at 4..20, BREAK at 22
    BreakPC   = 7'd5;
    pcLoadVal = '0;
    pcLoad    = 1'b1;
    Mode      = MODE_BREAK;
    applyStimulus(1, 64'h0, m);
    pcLoad = 1'b0;
    applyStimulus(21, 64'h1, m);
    checkOutput("bp_steps", m, 64'h111110);
    checkOutput("bp_settle_state", State, S_SETTLE);
    checkOutput("bp_settle_hit", BreakHit, 0);
    applyStimulus(1, 64'h0, m);
    checkOutput("bp_hit", BreakHit, 1);
    checkOutput("bp_state", State, S_BREAK);
    checkOutput("bp_running", Running, 0);
    applyStimulus(8, 64'h0, m);
    checkOutput("bp_hold_nostep", m, 64'h0);
    applyStimulus(2, 64'h1, m);
    checkOutput("bp_clear_hit", BreakHit, 0);
    checkOutput("bp_clear_state", State, S_IDLE);
    checkOutput("bp_count", StepCount, 12);

    // Start at the breakpoint: runs until PC wraps back (128 steps)
    BreakPC   = '0;
    pcLoadVal = '0;
    pcLoad    = 1'b1;
    applyStimulus(1, 64'h0, m);
    pcLoad = 1'b0;
    applyStimulus(1, 64'h1, m);
    nSteps = 0;
    hit    = 1'b0;
    for (int i = 0; i < 600 && !hit; i++) begin
      applyStimulus(1, 64'h0, m);
      if (m[0]) nSteps++;
      hit = BreakHit;
    end
    checkOutput("wrap_steps", nSteps, 128);
    checkOutput("wrap_hit", hit, 1);
    applyStimulus(2, 64'h1, m);
    checkOutput("wrap_clear_state", State, S_IDLE);
    checkOutput("wrap_count", StepCount, 12);
`else
    // Without breakpoints Mode 10 free-runs and never reports a hit
    Mode    = MODE_BREAK;
    BreakPC = '0;
    applyStimulus(30, 64'h1, m);
    checkOutput("m10_steps", m, 64'h11111110);
    checkOutput("m10_hit", BreakHit, 0);
    checkOutput("m10_state", State, S_RUN);
    applyStimulus(2, 64'h1, m);
    checkOutput("m10_stop_nostep", m, 64'h0);
    checkOutput("m10_stop_state", State, S_IDLE);
    checkOutput("m10_count", StepCount, 14);
`endif

    // Free-run 17 steps from reset with a 4-bit counter -> wraps to 1
    Reset = 1'b1;
    applyStimulus(2, 64'h0, m);
    Reset = 1'b0;
    checkOutput("fr_reset_count", StepCount, 0);
    Mode = MODE_FREE;
    applyStimulus(1, 64'h1, m);
    Mode = MODE_SINGLE;
    nSteps = 0;
    for (int i = 1; i <= 68; i++) begin
      applyStimulus(1, 64'h0, m);
      if (m[0]) nSteps++;
    end
    checkOutput("fr_steps", nSteps, 17);
    checkOutput("fr_count_wrap", StepCount, 1);
    checkOutput("fr_mode_ignored", State, S_RUN);

    // Strobe on the tick cycle (72): no step, back to idle
    applyStimulus(4, 64'h8, m);
    checkOutput("coincide_nostep", m, 64'h0);
    checkOutput("coincide_state", State, S_IDLE);
    checkOutput("coincide_running", Running, 0);
    checkOutput("coincide_count", StepCount, 1);

    // Reset during RUN the cycle before the first tick
    Mode = MODE_FREE;
    applyStimulus(3, 64'h1, m);
    checkOutput("rr_pre_nostep", m, 64'h0);
    checkOutput("rr_pre_running", Running, 1);
    Reset = 1'b1;
    applyStimulus(1, 64'h0, m);
    Reset = 1'b0;
    @(negedge Clk);
    checkOutput("rr_step", Step, 0);
    checkOutput("rr_state", State, S_IDLE);
    checkOutput("rr_running", Running, 0);
    checkOutput("rr_breakhit", BreakHit, 0);
    checkOutput("rr_count", StepCount, 0);
    @(posedge Clk);
    #1;
    applyStimulus(8, 64'h0, m);
    checkOutput("rr_after_nostep", m, 64'h0);

    checkOutput("no_back_to_back", backToBack, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/run_controller.md
# run_controller

Sequencing controller for the 16-bit processor: turns the debounced key strobe into single-cycle step enables for the processor. Supports single-step, fixed-length burst, free-run and run-to-breakpoint modes, paced by an internal rate divider. Sits between the key filter and the processor in the top level. Exposes run status and a step counter for the HEX/LED debug mux.

## Interface
- PC_W, 7, processor PC width
- CNT_W, 16, step counter width
- RUN_DIV, 25_000_000, Clk cycles between steps while running (≥2)
- BURST_N, 16, steps issued per burst (≥1)

Ports:
- Clk  in  1  system clock; one clock domain
- Reset  in  1  synchronous, active-high
- Strobe  in  1  one-cycle pulse from key filter (start/step/stop)
- Mode  in  2  00 single, 01 burst, 10 run-to-break, 11 free-run
- BreakPC  in  PC_W  breakpoint address
- PC_In  in  PC_W  current processor PC
- Step  out  1  one-cycle processor enable
- Running  out  1  high in RUN/BURST/SETTLE
- BreakHit  out  1  high in BREAK
- State  out  3  encoded FSM state for debug display
- StepCount  out  CNT_W  total Step pulses since reset, wraps

## Operation
- States: IDLE, SINGLE, BURST, RUN, SETTLE, BREAK.
- IDLE: on Strobe, Mode is latched into ModeQ, and the divider is cleared.
  - 00 → SINGLE.
  - 01 → BURST with BurstLeft=BURST_N.
  - 10 or 11 → RUN.
- Mode changes are ignored outside IDLE.
- SINGLE: Step=1 for one cycle, then → IDLE.
- BURST: Step=1 on each divider tick and BurstLeft decrements. The tick that brings BurstLeft to 0 → IDLE. Strobe → IDLE immediately with no Step.
- RUN: Step=1 on each divider tick.
  - ModeQ=10: each Step goes to SETTLE.
  - ModeQ=11: stays in RUN.
  - Strobe → IDLE with no Step.
  - If Strobe and tick coincide, Strobe wins and no Step is issued.
- SETTLE: one cycle. If PC_In==BreakPC → BREAK, else → RUN.
  - The first compare happens only after the first Step, so starting at BreakPC still advances.
  - Strobe in SETTLE → IDLE.
- BREAK: no Steps issued. Strobe → IDLE.
- StepCount increments on every Step cycle and wraps from 2^CNT_W−1 to 0.
- Divider counts 0..RUN_DIV−1. A tick occurs on the cycle the count equals RUN_DIV−1. It runs only in BURST/RUN/SETTLE and is held at 0 otherwise.

## Timing
- Reset values: Step=0, Running=0, BreakHit=0, State=IDLE, StepCount=0, divider=0, BurstLeft=0, ModeQ=00.
- Reset mid-operation aborts any run in the same cycle, with no further Step.
- Single: Strobe at cycle t → Step high at t+1 only.
- Burst/run: first Step at t+RUN_DIV, then every RUN_DIV cycles; SETTLE does not stretch the period.
- Step is never high for two consecutive cycles.
- Breakpoint: a Step at cycle s moves the FSM to SETTLE at s+1. BREAK and BreakHit=1 follow at s+2 if PC_In matched at s+1.
- Running and BreakHit are registered and track State.

## Configuration
- BREAKPOINT_EN defined: behaviour as above.
- BREAKPOINT_EN not defined:
  - Mode 10 behaves as 11.
  - SETTLE and BREAK are unreachable.
  - BreakHit is tied to 0 and the BreakPC/PC_In compare logic is removed.

## Structure
- Package proc_ctrl_pkg holds:
  - the state enum with its fixed 3-bit encoding (IDLE=0, SINGLE=1, BURST=2, RUN=3, SETTLE=4, BREAK=5);
  - the Mode constants.
- Sub-module rate_divider (Clk, Reset, Clear, Enable → Tick), parameterised by RUN_DIV.

## Test plan
- Reset, Mode=00, Strobe ×3 → three isolated Step pulses, each one cycle after its Strobe; StepCount=3.
- RUN_DIV=4, BURST_N=3, Mode=01, Strobe at t → Step at t+4, t+8, t+12, then State=IDLE; Strobe at t+6 instead → only one Step.
- RUN_DIV=4, Mode=10, BreakPC=5, model PC increments on Step from 0 → exactly 5 Steps; BreakHit=1 two cycles after the 5th; next Strobe clears it.
- Mode=10, PC starts at BreakPC=0 → run continues past PC 0 until PC wraps back to 0 (128 Steps).
- CNT_W=4, free-run 17 Steps → StepCount=1; Strobe coincident with a tick → no Step, State=IDLE.
- Reset asserted in RUN one cycle before a tick → no Step, all outputs at reset values the next cycle.
